// File: rtl/dpram_scan_m.sv
// dpram_scan_m
//   Streams a contiguous (optionally wrapping) address range out of the
//   application read port of a dual-port RAM.
//
//   The DPRAM read port is synchronous. Data for the address presented on
//   app_addr appears on app_data one cycle after the read issues. Each
//   returning word goes into a 2-entry output buffer. A read is issued only
//   when a buffer slot is guaranteed to be free, so backpressure never drops
//   a word.
//
// Ports
//   clk, rst               single clock; synchronous active-high reset
//   start, abort           one-cycle scan request / cancel
//   first_addr, last_addr  inclusive scan range, sampled with start
//   app_addr, app_data     DPRAM application read port
//   out_data, out_valid,   output stream (valid/ready handshake);
//   out_ready, out_last    out_last marks the final word of a pass
//   busy                   scan in progress (RUN or DRAIN)
//   done                   one-cycle pulse after the out_last transfer
//   loop                   only with DPRAM_SCAN_REPEAT_EN: repeat the range
//
// Build option
//   DPRAM_SCAN_REPEAT_EN   adds the loop input for continuous repeated passes
module dpram_scan_m #(
  parameter int unsigned APP_AW = 8,
  parameter int unsigned APP_DW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
`ifdef DPRAM_SCAN_REPEAT_EN
  input  logic              loop,
`endif
  input  logic [APP_AW-1:0] first_addr,
  input  logic [APP_AW-1:0] last_addr,
  output logic [APP_AW-1:0] app_addr,
  input  logic [APP_DW-1:0] app_data,
  output logic [APP_DW-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [APP_AW-1:0] first_q, first_d;
  logic [APP_AW-1:0] last_q, last_d;
  logic [APP_AW-1:0] addr_q, addr_d;
  logic              infl_q, infl_d;        // read issued last cycle
  logic              infl_last_q, infl_last_d;
  logic [1:0]        cnt_q, cnt_d;          // buffered words (0..2)
  logic [APP_DW-1:0] buf0_q, buf0_d;        // head entry, drives out_data
  logic [APP_DW-1:0] buf1_q, buf1_d;
  logic              lst0_q, lst0_d;
  logic              lst1_q, lst1_d;
  logic              done_q, done_d;

  logic              loop_en;
  logic              pop;
  logic              push;
  logic [2:0]        occ;
  logic              rd_fire;
  logic              rd_last;
  logic              kill;

`ifdef DPRAM_SCAN_REPEAT_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = buf0_q;
  assign out_last  = out_valid & lst0_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign app_addr  = addr_q;

  assign pop  = out_valid & out_ready;
  assign push = infl_q;

  // Slots committed after this cycle: buffered plus in flight, less the
  // word leaving now. A new read may take a slot only if one remains.
  // pop implies cnt_q >= 1, so the subtraction cannot underflow.
  assign occ     = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
  assign rd_fire = (state_q == S_RUN) && (occ < 3'd2);
  assign rd_last = (addr_q == last_q);
  assign kill    = abort && (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    last_d      = last_q;
    addr_d      = addr_q;
    infl_d      = rd_fire;
    infl_last_d = rd_fire & rd_last;
    cnt_d       = cnt_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    lst0_d      = lst0_q;
    lst1_d      = lst1_q;
    done_d      = pop & out_last;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          first_d = first_addr;
          last_d  = last_addr;
          addr_d  = first_addr;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (rd_fire) begin
          if (rd_last && loop_en) begin
            addr_d = first_q;
          end else begin
            addr_d = addr_q + APP_AW'(1);
          end
          if (rd_last && !loop_en) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pop && out_last) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Two-entry buffer. Entry 0 is always the head, so out_data and out_last
    // stay unchanged unless the head is popped.
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          buf0_d = app_data;
          lst0_d = infl_last_q;
        end else begin
          buf1_d = app_data;
          lst1_d = infl_last_q;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        lst0_d = lst1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          buf0_d = app_data;
          lst0_d = infl_last_q;
        end else begin
          buf0_d = buf1_q;
          lst0_d = lst1_q;
          buf1_d = app_data;
          lst1_d = infl_last_q;
        end
      end
      default: ;
    endcase

    // Abort overrides everything. The returning word is discarded, the buffer
    // is emptied, and no done pulse is generated for the cancelled scan.
    if (kill) begin
      state_d     = S_IDLE;
      addr_d      = addr_q;
      infl_d      = 1'b0;
      infl_last_d = 1'b0;
      cnt_d       = 2'd0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      first_q     <= '0;
      last_q      <= '0;
      addr_q      <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      cnt_q       <= 2'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      lst0_q      <= 1'b0;
      lst1_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      cnt_q       <= cnt_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      lst0_q      <= lst0_d;
      lst1_q      <= lst1_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: doc/dpram_scan_m.md
DPRAM_SCAN_M -- requirements
Module: dpram_scan_m

Interface
REQ-001 SHALL have parameter APP_AW, default 8: app-port address width.
REQ-002 SHALL have parameter APP_DW, default 8: app-port data width.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a scan.
REQ-006 SHALL have port abort  input  1  one-cycle request to cancel a scan.
REQ-007 SHALL have port first_addr  input  APP_AW  first entry of the scan, sampled with start.
REQ-008 SHALL have port last_addr  input  APP_AW  final entry of the scan, sampled with start.
REQ-009 SHALL have port app_addr  output  APP_AW  DPRAM app-port read address, registered.
REQ-010 SHALL have port app_data  input  APP_DW  DPRAM app-port read data, valid one cycle after app_addr.
REQ-011 SHALL have port out_data  output  APP_DW  stream data.
REQ-012 SHALL have port out_valid  output  1  stream data valid.
REQ-013 SHALL have port out_ready  input  1  stream consumer ready; a transfer occurs when out_valid and out_ready are both high.
REQ-014 SHALL have port out_last  output  1  marks the final word of a scan.
REQ-015 SHALL have port busy  output  1  high in RUN or DRAIN.
REQ-016 SHALL have port done  output  1  one-cycle pulse after the out_last transfer.

Function
REQ-017 SHALL use FSM states IDLE, RUN and DRAIN.
REQ-018 IDLE with start=1 and abort=0 SHALL latch first_addr and last_addr, load app_addr=first_addr and go to RUN next cycle.
REQ-019 Scan length SHALL be ((last_addr - first_addr) mod 2^APP_AW) + 1 words; first_addr==last_addr gives 1 word.
REQ-020 If last_addr < first_addr, the scan SHALL wrap from 2^APP_AW-1 to 0.
REQ-021 Each RUN cycle with a free credit SHALL issue one read and advance app_addr by 1 modulo 2^APP_AW.
REQ-022 SHALL have a 2-entry output buffer; a read SHALL issue only when buffered words plus in-flight reads minus a same-cycle pop is less than 2.
REQ-023 app_data SHALL be captured into the buffer exactly one cycle after its read issues.
REQ-024 If start is sampled at cycle T and out_ready is held high: first out_valid SHALL be at T+3, followed by one word per cycle with no bubbles.
REQ-025 out_data and out_last SHALL stay stable while out_valid=1 and out_ready=0; words SHALL never be dropped or duplicated.
REQ-026 After the last read issues, the FSM SHALL go RUN->DRAIN; DRAIN->IDLE on the out_last transfer, with done=1 in the following cycle.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 abort in RUN or DRAIN SHALL go to IDLE next cycle, flush the buffer and discard in-flight data.
REQ-029 After an abort, out_valid SHALL be 0 from the next cycle; out_last and done SHALL not assert for the aborted scan.
REQ-030 start and abort together in IDLE SHALL cause no scan; abort in IDLE SHALL have no effect.
REQ-031 app_addr SHALL hold its value in IDLE and DRAIN.

Reset
REQ-032 With rst=1, the next edge SHALL set state=IDLE, app_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0, and clear the buffer and credits.
REQ-033 rst during a scan SHALL behave as abort and discard all words; rst SHALL take priority over start and abort.

Configuration
REQ-034 With DPRAM_SCAN_REPEAT_EN defined, the block SHALL add input port loop (1 bit).
REQ-035 With DPRAM_SCAN_REPEAT_EN defined and loop=1 when the last read issues, the FSM SHALL stay in RUN and restart at the latched first_addr with no bubble.
REQ-036 In repeat mode, out_last SHALL mark each pass end, done SHALL pulse after each pass, and only abort or rst SHALL stop the scan.
REQ-037 Without DPRAM_SCAN_REPEAT_EN, port loop SHALL be absent and every scan SHALL be single-pass.

Verification
REQ-038 Basic scan: first=0x10, last=0x13, ready=1, start at T -> out_data = mem[0x10..0x13] at T+3..T+6; out_last at T+6; done at T+7.
REQ-039 Wrap: first=0xFE, last=0x01 -> 4 words from 0xFE, 0xFF, 0x00, 0x01; out_last on the 0x01 word.
REQ-040 Backpressure: first=0x00, last=0x07, ready toggling 1,0,0,1,... -> all 8 words in order, no loss or duplication, outputs stable while stalled.
REQ-041 Abort: abort 2 cycles after the first out_valid of a 16-word scan -> out_valid=0 next cycle, no out_last, no done, busy=0.
REQ-042 Edge cases: first=last=0x55 -> 1 word with out_last=1; start during busy -> ignored; rst mid-scan -> all outputs return to reset values.
REQ-043 DPRAM_SCAN_REPEAT_EN defined, loop=1, first=0x00, last=0x02 -> continuous sequence 0,1,2,0,1,2,... with out_last and done each pass.
